// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard FSM states and register-field width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hzst_t;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe latches and PC,
// with saturating stall and redirect counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             idex_memread,
  input  regbits_t         idex_rd,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzst_t state_q, state_d;
  logic  halted_q;
  logic  dreq, dstall, lu;
  logic  redir_fire;
  logic  stall_inc;

  assign dreq   = mem_dren | mem_dwen;
  assign dstall = dreq & ~dhit;
  assign lu     = idex_memread
                & (idex_rd != REG_ZERO)
                & ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_halt && !dstall) state_d = HALT;
        else if (dstall)         state_d = DWAIT;
      end
      DWAIT: begin
        if (mem_halt && !dstall) state_d = HALT;
        else if (dhit)           state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign halted = halted_q;

  // Highest priority first; a frozen pipe also holds a pending redirect.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    redir_fire  = 1'b0;
    priority case (1'b1)
      !nRST:             ;
      (state_q == HALT): ;
      dstall:            ;
      mem_redirect: begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        redir_fire  = 1'b1;
      end
      lu: begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
      !ihit: begin
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
      default: begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    endcase
  end

  assign stall_inc = nRST & ~pc_en & (state_q != HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (redir_fire),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Decisions come from memory handshakes (ihit/dhit), load-use hazards, MEM-stage redirects and HALT. Also keeps saturating stall and flush performance counters for the bench and debug.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.

Ports:
CLK  in  1  system clock, rising-edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction fetch completed this cycle.
dhit  in  1  data access completed this cycle.
mem_dren  in  1  MEM-stage instruction is a load.
mem_dwen  in  1  MEM-stage instruction is a store.
mem_redirect  in  1  MEM stage resolved a taken branch or jr; PC loads the target.
mem_halt  in  1  MEM-stage instruction is HALT.
idex_memread  in  1  ID/EX holds a load.
idex_rd  in  5  destination register of the ID/EX load.
ifid_rs  in  5  rs field of the IF/ID instruction.
ifid_rt  in  5  rt field of the IF/ID instruction.
pc_en  out  1  PC update enable.
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
ifid_flush, idex_flush, exmem_flush  out  1 each  latch flushes (insert bubble); flush overrides enable in the latches.
halted  out  1  registered; pipeline stopped on HALT.
stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted.
flush_cnt  out  CNT_W  number of redirect events.

Behaviour:
- Reset (nRST=0, async): state=RUN, halted=0, both counters=0. All enables and flushes are forced to 0 combinationally while nRST=0.
- Derived terms:
  - dreq = mem_dren | mem_dwen.
  - dstall = dreq & ~dhit.
  - lu = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs | idex_rd == ifid_rt).
- States (hzst_t): RUN, DWAIT, HALT.
- Transitions:
  - RUN → DWAIT when dstall.
  - DWAIT → RUN when dhit.
  - RUN/DWAIT → HALT when mem_halt & ~dstall. MEM/WB captures the HALT instruction on that edge.
  - HALT is terminal until reset.
  - DWAIT is entered and left combinationally consistent: outputs depend on dstall directly, so the state register is informational and counted.
- Output priority, first match wins:
  1. state==HALT: all enables 0, all flushes 0.
  2. dstall: all enables 0, flushes 0. Whole pipe frozen, including a pending redirect or load-use.
  3. mem_redirect: pc_en=1 regardless of ihit. ifid_flush=idex_flush=exmem_flush=1. memwb_en=1.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. One bubble per load; the next cycle lu clears naturally.
  5. ~ihit: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1. A bubble enters ID.
  6. Otherwise all enables 1, flushes 0.
- Simultaneous events:
  - dhit together with redirect: rule 3 applies in the same cycle.
  - mem_halt together with redirect: redirect applies, HALT entered next cycle.
  - lu together with ~ihit: rule 4 (PC held either way).
- Counters:
  - stall_cnt increments each cycle pc_en=0 and state!=HALT, saturating at all-ones.
  - flush_cnt increments on each cycle rule 3 fires, saturating.
  - Both are frozen in HALT.
- halted: registered, 1 from the cycle after HALT is entered.
- Reset mid-DWAIT or in HALT returns to RUN with counters cleared.

Decomposition:
- In cpu_types_pkg: hzst_t enum {RUN, DWAIT, HALT} and regbits_t (5-bit) for the register fields.
- One sub-module, sat_counter (CNT_W parameter, inc, count, async reset). Instantiated twice.
- Hazard compare and priority encoding stay inline.

Test Plan:
1. Reset, then ihit=1, no hazards → all enables 1, flushes 0, stall_cnt=0 after 10 cycles.
2. mem_dren=1, dhit low for 3 cycles then 1 → enables 0 for 3 cycles with no flushes, state DWAIT, stall_cnt=3; all enables 1 on the dhit cycle.
3. idex_memread=1, idex_rd=8, ifid_rt=8 → pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle. Repeat with idex_rd=0 → no stall.
4. mem_redirect=1 with ihit=0 → pc_en=1, three flushes asserted, flush_cnt increments 0→1.
5. mem_halt=1 with mem_dwen=1, dhit delayed 2 cycles → frozen for 2 cycles, HALT entered, halted=1 the cycle after; counters frozen; nRST pulse returns RUN, halted=0.
6. Force stall_cnt to saturation (CNT_W=4 build) → holds at 15.
